// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state type and parameter legality helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } dmem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  function automatic bit latency_ok(int lat);
    return (lat >= 1) && (lat <= 15);
  endfunction

  function automatic bit depth_ok(int d);
    return (d >= 4) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 single-port word array: synchronous write, comb read.
// Ports: clk, we, idx (word index), wdata, rdata.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MIPS memory stage.
// Ports: clk, reset (async, active-low), MemReqM, MemWriteM,
// ALUOutM (byte addr), WriteDataM, ReadDataM, StallM, MisalignM.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM
);

  localparam int AW  = $clog2(DEPTH);
  localparam int OFS = $clog2(WORD_BYTES);

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("dmem_responder: LATENCY %0d not in 1..15", LATENCY);
  end

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("dmem_responder: DEPTH %0d not a power of two >= 4", DEPTH);
  end

  dmem_state_t      state;
  dmem_state_t      state_n;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic             mis_q;
  logic             stall;

  logic [AW-1:0]    idx_in;
  logic             mis_in;
  logic [AW-1:0]    ram_idx;
  logic [31:0]      ram_rdata;
  logic             ram_we;
  logic             unused_addr;

  assign idx_in      = ALUOutM[AW+OFS-1:OFS];
  assign mis_in      = |ALUOutM[OFS-1:0];
  assign unused_addr = ^ALUOutM[31:AW+OFS];

  // Only IDLE reads from the live address; later states use the latch.
  assign ram_idx = (state == IDLE) ? idx_in : idx_q;
  assign ram_we  = (state == DONE) & we_q & ~mis_q;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        stall = MemReqM;
        if (MemReqM) state_n = (LATENCY == 1) ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == '0) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      ReadDataM <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (MemReqM) begin
            idx_q   <= idx_in;
            wdata_q <= WriteDataM;
            we_q    <= MemWriteM;
            mis_q   <= mis_in;
            if (LATENCY == 1) ReadDataM <= ram_rdata;
            else cnt <= CNT_W'(LATENCY - 2);
          end
        end
        WAIT: begin
          if (cnt == '0) ReadDataM <= ram_rdata;
          else cnt <= cnt - 1'b1;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  // Gate with reset so the stall drops the moment reset asserts.
  assign StallM    = stall & reset;
  assign MisalignM = (state == DONE) & mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder at LATENCY 1, 2, 4 and 15.
// Four instances share address/data inputs; each has its own request.
module tb_dmem_responder;

  function automatic int lat_of(int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 15;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd [4];
  logic [3:0]  stall;
  logic [3:0]  mis;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl   [4][64];
  bit          valid [4][64];
  logic [31:0] last  [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .DEPTH   (64),
      .LATENCY (lat_of(g))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .MemReqM    (req[g]),
      .MemWriteM  (we),
      .ALUOutM    (addr),
      .WriteDataM (wdata),
      .ReadDataM  (rd[g]),
      .StallM     (stall[g]),
      .MisalignM  (mis[g])
    );
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_quiet(string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s stall[%0d]", tag, d), 32'(stall[d]), 32'd0);
      chk($sformatf("%s rd[%0d]", tag, d), rd[d], 32'd0);
      chk($sformatf("%s mis[%0d]", tag, d), 32'(mis[d]), 32'd0);
    end
  endtask

  // One access on instance d; returns in its DONE cycle.
  task automatic access(int d, bit w, logic [31:0] a, logic [31:0] wd);
    int n;
    int i;
    bit m;
    i = int'((a >> 2) % 64);
    m = (a[1:0] != 2'b00);
    @(negedge clk);
    req[d] = 1'b1;
    we     = w;
    addr   = a;
    wdata  = wd;
    #1;
    chk($sformatf("idle rd stable d%0d", d), rd[d], last[d]);
    n = 0;
    while (stall[d] && n < 40) begin
      n++;
      @(negedge clk);
      req[d] = 1'b0;
      we     = $urandom_range(0, 1);
      addr   = $urandom;
      wdata  = $urandom;
      #1;
    end
    chk($sformatf("stall cycles d%0d a%h", d, a), n, lat_of(d));
    chk($sformatf("done mis d%0d a%h", d, a), 32'(mis[d]), 32'(m));
    chk($sformatf("done stall d%0d", d), 32'(stall[d]), 32'd0);
    if (valid[d][i])
      chk($sformatf("rdata d%0d a%h", d, a), rd[d], mdl[d][i]);
    last[d] = rd[d];
    if (w && !m) begin
      mdl[d][i]   = wd;
      valid[d][i] = 1'b1;
    end
  endtask

  initial begin
    req   = '0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    reset = 1'b0;
    for (int d = 0; d < 4; d++) begin
      last[d] = '0;
      for (int k = 0; k < 64; k++) valid[d][k] = 1'b0;
    end

    // Reset then idle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_quiet("in reset");
    end
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk_quiet("idle");
    end

    // Store then load, address wrap, misaligned store (LATENCY 2).
    access(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    access(1, 1'b0, 32'h0000_0010, 32'h0);
    chk("load 0x10", rd[1], 32'hDEAD_BEEF);
    access(1, 1'b1, 32'h0000_0104, 32'h1234_5678);
    access(1, 1'b0, 32'h0000_0004, 32'h0);
    chk("wrap load 0x4", rd[1], 32'h1234_5678);
    access(1, 1'b1, 32'h0000_0013, 32'hFFFF_FFFF);
    access(1, 1'b0, 32'h0000_0010, 32'h0);
    chk("after misaligned store", rd[1], 32'hDEAD_BEEF);

    // Reset in the 2nd WAIT cycle of a store (LATENCY 4).
    access(2, 1'b1, 32'h0000_0020, 32'h1111_2222);
    @(negedge clk);
    req[2] = 1'b1;
    we     = 1'b1;
    addr   = 32'h0000_0020;
    wdata  = 32'hA5A5_A5A5;
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    #1;
    chk("2nd wait stall", 32'(stall[2]), 32'd1);
    reset = 1'b0;
    #1;
    chk_quiet("async reset");
    for (int d = 0; d < 4; d++) last[d] = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    access(2, 1'b0, 32'h0000_0020, 32'h0);
    chk("aborted store", rd[2], 32'h1111_2222);

    // Latency sweep, back-to-back.
    for (int d = 0; d < 4; d += 3) begin
      access(d, 1'b1, 32'h0, 32'hC0DE_0000 + d);
      access(d, 1'b1, 32'h4, 32'hC0DE_1000 + d);
      access(d, 1'b0, 32'h0, 32'h0);
      chk($sformatf("sweep load 0 d%0d", d), rd[d], 32'hC0DE_0000 + d);
      access(d, 1'b0, 32'h4, 32'h0);
      chk($sformatf("sweep load 4 d%0d", d), rd[d], 32'hC0DE_1000 + d);
    end

    // Randomized accesses against the word-array model.
    for (int t = 0; t < 150; t++) begin
      int          d;
      logic [31:0] a;
      d = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      access(d, 1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the memory-stage port of the pipelined MIPS core.
- Accepts the core's word load/store request (address, write data, write enable) and returns read data after a fixed, parameterised number of wait cycles.
- Drives StallM to the hazard unit so that F/D/E/M hold and W is bubbled while an access is in progress.
- Replaces the zero-latency behavioural data memory. It models slow memory for hazard-unit and stall verification.

Parameters:
- DEPTH, 64: number of 32-bit words; must be a power of two, at least 4.
- LATENCY, 2: number of stall cycles per access; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- MemReqM  in  1  access request this cycle; the core drives it as MemtoRegM | MemWriteM
- MemWriteM  in  1  1 = store, 0 = load; valid only with MemReqM
- ALUOutM  in  32  byte address
- WriteDataM  in  32  store data
- ReadDataM  out  32  registered read data; sampled by the core at the edge that ends the DONE cycle
- StallM  out  1  1 = access pending, hold the pipeline
- MisalignM  out  1  high in DONE only if the latched address had addr[1:0] != 0

Behaviour:
- Reset: asynchronous, active-low, from any state.
  - State = IDLE, counter = 0, ReadDataM = 0, StallM = 0, MisalignM = 0.
  - Latched request is cleared and any pending store is dropped.
  - RAM contents are not cleared.
- Index: idx = addr[log2(DEPTH)+1 : 2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- State IDLE:
  - StallM = MemReqM (combinational).
  - On an edge with MemReqM = 1, latch addr, wdata, we and misalign.
  - If LATENCY = 1: load ReadDataM <= mem[idx] and go to DONE.
  - Otherwise: set cnt <= LATENCY-2 and go to WAIT.
- State WAIT:
  - StallM = 1. Inputs are ignored; only the latched copy is used.
  - If cnt == 0: load ReadDataM <= mem[idx_latched] and go to DONE.
  - Otherwise decrement cnt.
- State DONE:
  - StallM = 0, MisalignM = latched misalign.
  - At the closing edge, if we_latched = 1 and misalign = 0, write mem[idx] <= wdata. Always go to IDLE.
  - A misaligned store is suppressed. A misaligned load returns the word at idx.
- Stall count: StallM is high for exactly LATENCY consecutive cycles per access. DONE follows immediately, and the next request is evaluated in the IDLE cycle after DONE (back-to-back accesses are separated by one non-stall cycle).
- Stores: ReadDataM is loaded with the old word (read-before-write). The core ignores it.
- Stable ReadDataM: ReadDataM holds its value until the next load point; it never changes in IDLE.
- Reset mid-operation:
  - Reset during WAIT or DONE aborts the access: no write, StallM drops immediately (asynchronously).
  - After reset release, the first edge with MemReqM = 1 starts a fresh access.
- MemReqM = 0 in IDLE: no state change, StallM = 0.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t
  - constant WORD_BYTES = 4
  - the LATENCY legality check, done as an elaboration-time assertion
- One sub-module, dmem_array: a DEPTH×32 single-port array with synchronous write and combinational read, instantiated once.
- The FSM, counter, request latch and output register live in dmem_responder.

Test Plan:
- Reset then idle: hold reset = 0 for 3 cycles, release with MemReqM = 0 for 5 cycles -> ReadDataM = 0, StallM = 0 and MisalignM = 0 throughout.
- Store then load (LATENCY = 2, default): store 0xDEADBEEF to 0x0000_0010.
  - Store -> StallM high for exactly 2 cycles, then one DONE cycle.
  - Following load of 0x10 -> ReadDataM = 0xDEADBEEF in its DONE cycle, StallM again 2 cycles.
- Address wrap (DEPTH = 64): store 0x12345678 to 0x0000_0104, load 0x0000_0004 -> 0x12345678.
- Misaligned store (LATENCY = 2): store 0xFFFFFFFF to 0x0000_0013 -> MisalignM = 1 in DONE only. A later load of 0x10 still returns 0xDEADBEEF.
- Reset mid-access (LATENCY = 4): start a store of 0xA5A5A5A5 to 0x20 and assert reset in the 2nd WAIT cycle -> StallM falls asynchronously and ReadDataM = 0. A load of 0x20 after release returns the pre-store contents.
- Latency sweep: LATENCY = 1 and LATENCY = 15, back-to-back loads of 0x0 and 0x4.
  - StallM high for exactly 1 and 15 cycles respectively.
  - One non-stall cycle between accesses.
  - Data correct for both loads.
